// File: rtl/qr_engine.sv
// Pipelined Givens norm r = sqrt(a^2+b^2) feeding a 10-lane result history.
// Define QR_ROUND_EN to round the root to nearest instead of truncating.
module qr_engine #(
  parameter int I_DATA_W = 16,
  parameter int R_W      = 16,
  parameter int LANES    = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_trig,
  input  logic [2*I_DATA_W-1:0] i_data,
  output logic [LANES*R_W-1:0]  o_y_hat
);

`ifdef QR_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  typedef struct packed {
    logic        v;
    logic [15:0] root;
    logic [17:0] rem;
  } sq_t;

  // Four restoring-root iterations, consuming radicand pairs MSB first.
  function automatic sq_t sq_step(input sq_t s,
                                  input logic [7:0] pairs);
    sq_t        o;
    logic [19:0] r;
    logic [19:0] t;
    logic [7:0]  p;
    o = s;
    p = pairs;
    r = {2'b00, s.rem};
    for (int i = 0; i < 4; i++) begin
      r = {r[17:0], p[7:6]};
      p = {p[5:0], 2'b00};
      t = {2'b00, o.root, 2'b01};
      if (r >= t) begin
        r      = r - t;
        o.root = {o.root[14:0], 1'b1};
      end else begin
        o.root = {o.root[14:0], 1'b0};
      end
    end
    o.rem = r[17:0];
    return o;
  endfunction

  logic signed [15:0] a_s, b_s;
  logic signed [31:0] a_x, b_x;
  logic [31:0] a2_d, b2_d, a2_q, b2_q;
  logic [31:0] sum_d, sum_q;
  logic        v0_q, v1_q;
  logic [23:0] rad2_q;
  logic [15:0] rad3_q;
  logic [7:0]  rad4_q;
  sq_t         s_in;
  sq_t         s2_d, s3_d, s4_d, s5_d;
  sq_t         s2_q, s3_q, s4_q, s5_q;
  logic        rnd;
  logic [R_W-1:0] r_fin;
  logic [LANES-1:0][R_W-1:0] lane_d, lane_q;

  always_comb begin
    a_s  = $signed(i_data[31:16]);
    b_s  = $signed(i_data[15:0]);
    a_x  = 32'(a_s);
    b_x  = 32'(b_s);
    a2_d = a_x * a_x;
    b2_d = b_x * b_x;
    sum_d = a2_q + b2_q;
  end

  always_comb begin
    s_in = '{v: v1_q, root: 16'd0, rem: 18'd0};
    s2_d = sq_step(s_in, sum_q[31:24]);
    s3_d = sq_step(s2_q, rad2_q[23:16]);
    s4_d = sq_step(s3_q, rad3_q[15:8]);
    s5_d = sq_step(s4_q, rad4_q);
  end

  // Remainder exceeding root means the true root is above root+0.5.
  always_comb begin
    rnd   = ROUND && ({2'b00, s5_q.root} < s5_q.rem);
    r_fin = s5_q.root + {15'd0, rnd};
    lane_d = lane_q;
    if (s5_q.v) begin
      lane_d = {lane_q[LANES-2:0], r_fin};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
      a2_q   <= '0;
      b2_q   <= '0;
      sum_q  <= '0;
      rad2_q <= '0;
      rad3_q <= '0;
      rad4_q <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      s4_q   <= '0;
      s5_q   <= '0;
      lane_q <= '0;
    end else begin
      v0_q   <= i_trig;
      a2_q   <= a2_d;
      b2_q   <= b2_d;
      v1_q   <= v0_q;
      sum_q  <= sum_d;
      rad2_q <= sum_q[23:0];
      rad3_q <= rad2_q[15:0];
      rad4_q <= rad3_q[7:0];
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      s4_q   <= s4_d;
      s5_q   <= s5_d;
      lane_q <= lane_d;
    end
  end

  assign o_y_hat = lane_q;

endmodule

// File: tb/tb_qr_engine.sv
// Directed and random bench for qr_engine against a queue-based model.
// Build with QR_ROUND_EN defined to check the rounding variant.
module tb_qr_engine;

`ifdef QR_ROUND_EN
  localparam int E2   = 11235;
  localparam int EMAX = 46341;
`else
  localparam int E2   = 11234;
  localparam int EMAX = 46340;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         trig;
  logic [31:0]  data;
  logic [159:0] yhat;

  int n_chk  = 0;
  int n_pass = 0;

  int hist[10];
  int pq_r[$];
  int pq_due[$];
  int cyc = 0;

  qr_engine dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_trig (trig),
    .i_data (data),
    .o_y_hat(yhat)
  );

  always #5 clk = ~clk;

  function automatic int ref_r(input int a, input int b);
    longint s, r;
    real    rt;
    s  = longint'(a) * a + longint'(b) * b;
    rt = $sqrt(real'(s));
    r  = longint'($floor(rt));
    while (r * r > s) r--;
    while ((r + 1) * (r + 1) <= s) r++;
`ifdef QR_ROUND_EN
    if (rt - real'(r) > 0.5) r++;
`endif
    return int'(r);
  endfunction

  function automatic int lane(input int k);
    return int'(yhat[16*k +: 16]);
  endfunction

  task automatic chk(input string nm, input int got,
                     input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
  endtask

  task automatic chk_zero(input string nm);
    n_chk++;
    if (yhat == '0) n_pass++;
    else $display("FAIL %s got=%h exp=0", nm, yhat);
  endtask

  task automatic step(input logic r, input logic t,
                      input int a, input int b);
    rst  = r;
    trig = t;
    data = {16'(a), 16'(b)};
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0);
  endtask

  // Model: each accepted sample becomes due six edges later.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      foreach (hist[i]) hist[i] = 0;
      pq_r.delete();
      pq_due.delete();
    end else begin
      if (pq_due.size() > 0 && pq_due[0] == cyc) begin
        for (int i = 9; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = pq_r.pop_front();
        void'(pq_due.pop_front());
      end
      if (trig) begin
        pq_r.push_back(ref_r(int'($signed(data[31:16])),
                             int'($signed(data[15:0]))));
        pq_due.push_back(cyc + 6);
      end
    end
  end

  initial forever begin
    logic [159:0] exp;
    @(negedge clk);
    for (int i = 0; i < 10; i++) exp[16*i +: 16] = 16'(hist[i]);
    n_chk++;
    if (yhat === exp) n_pass++;
    else $display("FAIL yhat cyc=%0d got=%h exp=%h", cyc, yhat, exp);
  end

  initial begin
    int v[5];
    int a, b;
    v[0] = -32768; v[1] = 32767; v[2] = 0; v[3] = 1; v[4] = -1;

    chk("model_345", ref_r(-3, 4), 5);
    chk("model_max", ref_r(-32768, -32768), EMAX);
    chk("model_t2", ref_r(-5066, 10028), E2);

    for (int n = 0; n < 3; n++) begin
      step(1'b1, 1'b1, 7, 9);
      chk_zero("t1_reset");
    end

    for (int n = 1; n <= 16; n++) begin
      step(1'b0, 1'b1, -5066, 10028);
      if (n <= 6) chk("t2_latency", lane(0), 0);
      else if (n == 7) chk("t2_first", lane(0), E2);
    end
    for (int k = 0; k < 10; k++) chk("t2_full", lane(k), E2);
    idle(8);

    step(1'b0, 1'b1, 3, 4);
    step(1'b0, 1'b1, 0, 0);
    step(1'b0, 1'b1, -32768, -32768);
    for (int j = 1; j <= 8; j++) begin
      step(1'b0, 1'b0, 0, 0);
      if (j == 4) chk("t3_five", lane(0), 5);
      if (j == 5) chk("t3_zero", lane(0), 0);
      if (j == 6) chk("t3_max", lane(0), EMAX);
    end
    chk("t3_l1", lane(1), 0);
    chk("t3_l2", lane(2), 5);
    chk("t3_l3", lane(3), E2);

    step(1'b0, 1'b1, -3, 4);
    step(1'b0, 1'b1, 3, -4);
    step(1'b0, 1'b1, -3, -4);
    idle(8);
    for (int k = 0; k < 3; k++) chk("sign", lane(k), 5);

    for (int k = 1; k <= 12; k++) step(1'b0, 1'b1, k, 0);
    idle(8);
    for (int i = 0; i < 10; i++) chk("t4_lane", lane(i), 12 - i);

    step(1'b0, 1'b1, 6, 8);
    step(1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b1, 5, 12);
    idle(8);
    chk("t5_l0", lane(0), 13);
    chk("t5_l1", lane(1), 10);
    chk("t5_l2", lane(2), 12);

    step(1'b0, 1'b1, 3, 4);
    step(1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 0, 0);
    for (int j = 0; j < 8; j++) begin
      step(1'b0, 1'b0, 0, 0);
      chk_zero("t6_flush");
    end

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        a = v[$urandom_range(0, 4)];
        b = v[$urandom_range(0, 4)];
      end else begin
        a = int'($signed(16'($urandom)));
        b = int'($signed(16'($urandom)));
      end
      step($urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)),
           a, b);
    end
    idle(8);

    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
